control_filtro: RTL and testbench
=================================

CONTROL_FILTRO -- requirements
Module: control_filtro

Interface
REQ-001 Parameter N, default 25, width of every sample, coefficient and arithmetic-stage operand (signed two's complement, shared fixed-point format).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 muestra_in  input  N  new input sample x[n].
REQ-005 muestra_valida  input  1  one-cycle strobe qualifying muestra_in.
REQ-006 coef_b0, coef_b1, coef_b2  input  N each  feed-forward coefficients.
REQ-007 coef_a1, coef_a2  input  N each  feedback coefficients, supplied pre-negated (block only adds).
REQ-008 Valores  input  N  truncated result Constantes_G*Multip_G+Entrada_G returned combinationally by the arithmetic stage.
REQ-009 Constantes_G  output  N  coefficient operand to the arithmetic stage.
REQ-010 Multip_G  output  N  sample operand to the arithmetic stage.
REQ-011 Entrada_G  output  N  running partial sum to the arithmetic stage.
REQ-012 muestra_out  output  N  filtered sample y[n], held until next result.
REQ-013 salida_valida  output  1  one-cycle pulse when muestra_out updates.
REQ-014 ocupado  output  1  high while a sample is being processed.
REQ-015 muestra_perdida  output  1  one-cycle pulse when a strobe is rejected.

Function
REQ-016 Block SHALL compute biquad DF-I: y[n]=b0*x[n]+b1*x[n-1]+b2*x[n-2]+a1*y[n-1]+a2*y[n-2], one product-accumulate per cycle through the external arithmetic stage.
REQ-017 Internal registers: x_reg, x1, x2, y1, y2, acc (all N bits), FSM state.
REQ-018 FSM states: IDLE, T0, T1, T2, T3, T4; IDLE->T0 on muestra_valida, Tk->Tk+1 unconditionally, T4->IDLE.
REQ-019 In IDLE with muestra_valida=1: x_reg <= muestra_in on that edge.
REQ-020 Operand pairs (Constantes_G, Multip_G): T0 (b0, x_reg), T1 (b1, x1), T2 (b2, x2), T3 (a1, y1), T4 (a2, y2).
REQ-021 Entrada_G SHALL be 0 in T0 and acc in T1..T4; acc <= Valores at end of each of T0..T3.
REQ-022 In IDLE, Constantes_G, Multip_G, Entrada_G SHALL be 0.
REQ-023 End of T4: muestra_out <= Valores; y2 <= y1; y1 <= Valores; x2 <= x1; x1 <= x_reg; salida_valida=1 for the following cycle only.
REQ-024 Latency: strobe sampled at edge E -> muestra_out valid and salida_valida high in the cycle after edge E+5; throughput one sample per 6 cycles (back-to-back strobe permitted in the salida_valida cycle).
REQ-025 ocupado SHALL be 1 in T0..T4, 0 in IDLE.
REQ-026 muestra_valida while ocupado=1: sample ignored, no state change, muestra_perdida pulses the next cycle.
REQ-027 No saturation in this block; overflow/truncation is owned by the arithmetic stage; Valores used as-is.
REQ-028 Coefficient inputs are sampled every cycle; changing them mid-sample affects only the remaining taps (caller holds them stable while ocupado=1).

Reset
REQ-029 reset=0 SHALL immediately force state IDLE and clear x_reg, x1, x2, y1, y2, acc, muestra_out, salida_valida, ocupado, muestra_perdida, and all operand outputs to 0, including mid-sample (partial result discarded, no salida_valida).
REQ-030 First strobe after reset release SHALL be processed with zero history.

Verification (bench replaces arithmetic stage with integer model Valores=Constantes_G*Multip_G+Entrada_G)
REQ-031 Impulse: b0=1,b1=2,b2=3,a1=a2=0; strobes x=1,0,0,0 every 6 cycles -> muestra_out 1,2,3,0, each with one salida_valida pulse 6 cycles after strobe.
REQ-032 Feedback: b0=1, others 0 except a1=1; x=5,0,0 -> y=5,5,5.
REQ-033 Latency/handshake: single strobe at edge E -> ocupado high cycles E+1..E+5, salida_valida only after edge E+5, operands 0 before and after.
REQ-034 Strobe while ocupado (2 cycles after first) -> muestra_perdida one pulse, output equals single-sample result.
REQ-035 Reset asserted in T2 -> all outputs 0 asynchronously, no salida_valida; next sample x=4, b0=1, a1=1 gives y=4 (history cleared).
REQ-036 Back-to-back strobe in salida_valida cycle accepted: no muestra_perdida, two consecutive results 6 cycles apart.

Source files
------------

// File: rtl/control_filtro.sv
// Biquad DF-I sequencer: feeds one coefficient/sample pair per cycle to an
// external multiply-accumulate stage and keeps the x/y history registers.
module control_filtro #(
   parameter int N = 25
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] muestra_in,
   input  logic         muestra_valida,
   input  logic [N-1:0] coef_b0,
   input  logic [N-1:0] coef_b1,
   input  logic [N-1:0] coef_b2,
   input  logic [N-1:0] coef_a1,
   input  logic [N-1:0] coef_a2,
   input  logic [N-1:0] Valores,
   output logic [N-1:0] Constantes_G,
   output logic [N-1:0] Multip_G,
   output logic [N-1:0] Entrada_G,
   output logic [N-1:0] muestra_out,
   output logic         salida_valida,
   output logic         ocupado,
   output logic         muestra_perdida
);

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] x_reg_q, x_reg_d;
   logic [N-1:0] x1_q, x1_d;
   logic [N-1:0] x2_q, x2_d;
   logic [N-1:0] y1_q, y1_d;
   logic [N-1:0] y2_q, y2_d;
   logic [N-1:0] acc_q, acc_d;
   logic [N-1:0] muestra_out_q, muestra_out_d;
   logic         salida_valida_q, salida_valida_d;
   logic         ocupado_q, ocupado_d;
   logic         muestra_perdida_q, muestra_perdida_d;

   always_comb begin
      state_d           = state_q;
      x_reg_d           = x_reg_q;
      x1_d              = x1_q;
      x2_d              = x2_q;
      y1_d              = y1_q;
      y2_d              = y2_q;
      acc_d             = acc_q;
      muestra_out_d     = muestra_out_q;
      salida_valida_d   = 1'b0;
      ocupado_d         = 1'b0;
      muestra_perdida_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (muestra_valida) begin
               x_reg_d   = muestra_in;
               state_d   = T0;
               ocupado_d = 1'b1;
            end
         end
         T0, T1, T2, T3: begin
            acc_d             = Valores;
            ocupado_d         = 1'b1;
            muestra_perdida_d = muestra_valida;
            case (state_q)
               T0:      state_d = T1;
               T1:      state_d = T2;
               T2:      state_d = T3;
               default: state_d = T4;
            endcase
         end
         T4: begin
            // Last tap: Valores is y[n]; shift both delay lines in the same edge.
            muestra_out_d     = Valores;
            y2_d              = y1_q;
            y1_d              = Valores;
            x2_d              = x1_q;
            x1_d              = x_reg_q;
            salida_valida_d   = 1'b1;
            muestra_perdida_d = muestra_valida;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Constantes_G = '0;
      Multip_G     = '0;
      Entrada_G    = acc_q;
      case (state_q)
         T0: begin
            Constantes_G = coef_b0;
            Multip_G     = x_reg_q;
            Entrada_G    = '0;
         end
         T1: begin
            Constantes_G = coef_b1;
            Multip_G     = x1_q;
         end
         T2: begin
            Constantes_G = coef_b2;
            Multip_G     = x2_q;
         end
         T3: begin
            Constantes_G = coef_a1;
            Multip_G     = y1_q;
         end
         T4: begin
            Constantes_G = coef_a2;
            Multip_G     = y2_q;
         end
         default: Entrada_G = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= IDLE;
         x_reg_q           <= '0;
         x1_q              <= '0;
         x2_q              <= '0;
         y1_q              <= '0;
         y2_q              <= '0;
         acc_q             <= '0;
         muestra_out_q     <= '0;
         salida_valida_q   <= 1'b0;
         ocupado_q         <= 1'b0;
         muestra_perdida_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         x_reg_q           <= x_reg_d;
         x1_q              <= x1_d;
         x2_q              <= x2_d;
         y1_q              <= y1_d;
         y2_q              <= y2_d;
         acc_q             <= acc_d;
         muestra_out_q     <= muestra_out_d;
         salida_valida_q   <= salida_valida_d;
         ocupado_q         <= ocupado_d;
         muestra_perdida_q <= muestra_perdida_d;
      end
   end

   assign muestra_out     = muestra_out_q;
   assign salida_valida   = salida_valida_q;
   assign ocupado         = ocupado_q;
   assign muestra_perdida = muestra_perdida_q;

endmodule

// File: tb/tb_control_filtro.sv
// Bench for control_filtro: integer arithmetic stage, a behavioural biquad
// model checked every cycle, and a few literal directed results.
module tb_control_filtro;
   localparam int N = 25;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] muestra_in = '0;
   logic         muestra_valida = 1'b0;
   logic [N-1:0] coef_b0 = '0, coef_b1 = '0, coef_b2 = '0, coef_a1 = '0, coef_a2 = '0;
   logic [N-1:0] valores;
   logic [N-1:0] constantes_g, multip_g, entrada_g, muestra_out;
   logic         salida_valida, ocupado, muestra_perdida;

   int checks = 0;
   int errors = 0;

   control_filtro #(.N(N)) dut (
      .clk             (clk),
      .reset           (reset),
      .muestra_in      (muestra_in),
      .muestra_valida  (muestra_valida),
      .coef_b0         (coef_b0),
      .coef_b1         (coef_b1),
      .coef_b2         (coef_b2),
      .coef_a1         (coef_a1),
      .coef_a2         (coef_a2),
      .Valores         (valores),
      .Constantes_G    (constantes_g),
      .Multip_G        (multip_g),
      .Entrada_G       (entrada_g),
      .muestra_out     (muestra_out),
      .salida_valida   (salida_valida),
      .ocupado         (ocupado),
      .muestra_perdida (muestra_perdida)
   );

   always #5 clk = ~clk;

   function automatic longint sx(logic [N-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [N-1:0] tr(longint v);
      return v[N-1:0];
   endfunction

   // Arithmetic stage stand-in: wraps to N bits.
   always_comb valores = tr(sx(constantes_g) * sx(multip_g) + sx(entrada_g));

   // Model: phase -1 idle, 0..4 = tap index being computed this cycle.
   int           m_phase = -1;
   logic [N-1:0] m_x = '0, m_x1 = '0, m_x2 = '0, m_y1 = '0, m_y2 = '0;
   logic [N-1:0] exp_out = '0;
   logic         exp_sv = 1'b0, exp_perd = 1'b0;

   function automatic logic [N-1:0] coef_at(int k);
      case (k)
         0: return coef_b0;
         1: return coef_b1;
         2: return coef_b2;
         3: return coef_a1;
         default: return coef_a2;
      endcase
   endfunction

   function automatic logic [N-1:0] samp_at(int k);
      case (k)
         0: return m_x;
         1: return m_x1;
         2: return m_x2;
         3: return m_y1;
         default: return m_y2;
      endcase
   endfunction

   // Sum of the first 'upto' products, modulo 2^N.
   function automatic logic [N-1:0] mac_sum(int upto);
      longint s = 0;
      for (int k = 0; k < upto; k++) s += sx(coef_at(k)) * sx(samp_at(k));
      return tr(s);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase  <= -1;
         m_x      <= '0;
         m_x1     <= '0;
         m_x2     <= '0;
         m_y1     <= '0;
         m_y2     <= '0;
         exp_out  <= '0;
         exp_sv   <= 1'b0;
         exp_perd <= 1'b0;
      end else begin
         exp_sv   <= 1'b0;
         exp_perd <= (m_phase >= 0) && muestra_valida;
         if (m_phase < 0) begin
            if (muestra_valida) begin
               m_x     <= muestra_in;
               m_phase <= 0;
            end
         end else if (m_phase == 4) begin
            exp_out <= mac_sum(5);
            exp_sv  <= 1'b1;
            m_x2    <= m_x1;
            m_x1    <= m_x;
            m_y2    <= m_y1;
            m_y1    <= mac_sum(5);
            m_phase <= -1;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   task automatic chk(string name, longint act, longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, expv);
      end
   endtask

   always @(negedge clk) begin
      chk("salida_valida", longint'(salida_valida), longint'(exp_sv));
      chk("muestra_perdida", longint'(muestra_perdida), longint'(exp_perd));
      chk("ocupado", longint'(ocupado), (m_phase >= 0) ? 1 : 0);
      chk("muestra_out", longint'(muestra_out), longint'(exp_out));
      if (m_phase < 0) begin
         chk("idle_constantes", longint'(constantes_g), 0);
         chk("idle_multip", longint'(multip_g), 0);
         chk("idle_entrada", longint'(entrada_g), 0);
      end else begin
         chk("tap_constantes", longint'(constantes_g), longint'(coef_at(m_phase)));
         chk("tap_multip", longint'(multip_g), longint'(samp_at(m_phase)));
         chk("tap_entrada", longint'(entrada_g), longint'(mac_sum(m_phase)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(int b0, int b1, int b2, int a1, int a2);
      coef_b0 = tr(b0);
      coef_b1 = tr(b1);
      coef_b2 = tr(b2);
      coef_a1 = tr(a1);
      coef_a2 = tr(a2);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Counts negedges until salida_valida, bounded.
   task automatic wait_sv(string name, int expv, int exp_lat);
      int  lat = 0;
      bit  got = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (salida_valida) begin
            lat = i;
            got = 1'b1;
            break;
         end
      end
      chk({name, "_seen"}, longint'(got), 1);
      if (got) begin
         chk({name, "_value"}, longint'(muestra_out), longint'(tr(expv)));
         chk({name, "_latency"}, lat, exp_lat);
      end
   endtask

   task automatic do_sample(string name, int x, int expv);
      muestra_in     = tr(x);
      muestra_valida = 1'b1;
      tick();
      muestra_valida = 1'b0;
      wait_sv(name, expv, 6);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) tick();
      chk("reset_muestra_out", longint'(muestra_out), 0);
      chk("reset_ocupado", longint'(ocupado), 0);
      chk("reset_salida_valida", longint'(salida_valida), 0);
      reset = 1'b1;
      tick();

      // Impulse through the feed-forward taps.
      set_coefs(1, 2, 3, 0, 0);
      do_sample("imp0", 1, 1);
      do_sample("imp1", 0, 2);
      do_sample("imp2", 0, 3);
      do_sample("imp3", 0, 0);

      // Feedback through a1.
      do_reset();
      set_coefs(1, 0, 0, 1, 0);
      do_sample("fb0", 5, 5);
      do_sample("fb1", 0, 5);
      do_sample("fb2", 0, 5);

      // Strobe while busy is dropped.
      do_reset();
      set_coefs(3, 0, 0, 0, 0);
      muestra_in     = tr(7);
      muestra_valida = 1'b1;
      tick();
      muestra_valida = 1'b0;
      tick();
      muestra_in     = tr(100);
      muestra_valida = 1'b1;
      tick();
      muestra_valida = 1'b0;
      @(negedge clk);
      chk("perdida_pulse", longint'(muestra_perdida), 1);
      @(negedge clk);
      chk("perdida_cleared", longint'(muestra_perdida), 0);
      wait_sv("drop", 21, 2);
      tick();

      // Asynchronous reset in T2 discards the partial result.
      set_coefs(1, 0, 0, 1, 0);
      muestra_in     = tr(9);
      muestra_valida = 1'b1;
      tick();
      muestra_valida = 1'b0;
      tick();
      tick();
      #1 reset = 1'b0;
      #1;
      chk("async_ocupado", longint'(ocupado), 0);
      chk("async_constantes", longint'(constantes_g), 0);
      chk("async_multip", longint'(multip_g), 0);
      chk("async_entrada", longint'(entrada_g), 0);
      chk("async_muestra_out", longint'(muestra_out), 0);
      chk("async_salida_valida", longint'(salida_valida), 0);
      tick();
      reset = 1'b1;
      repeat (6) tick();
      do_sample("post_reset", 4, 4);

      // Back-to-back strobe in the salida_valida cycle.
      do_reset();
      set_coefs(1, 0, 0, 0, 0);
      muestra_in     = tr(11);
      muestra_valida = 1'b1;
      tick();
      muestra_valida = 1'b0;
      repeat (5) tick();
      chk("b2b_first_valid", longint'(salida_valida), 1);
      chk("b2b_first_value", longint'(muestra_out), 11);
      muestra_in     = tr(12);
      muestra_valida = 1'b1;
      tick();
      muestra_valida = 1'b0;
      wait_sv("b2b_second", 12, 6);
      tick();

      // Random traffic, coefficients only changed while idle.
      do_reset();
      set_coefs(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      for (int i = 0; i < 600; i++) begin
         muestra_valida = ($urandom_range(0, 3) == 0);
         muestra_in     = tr(int'($urandom));
         if (m_phase < 0 && !muestra_valida && $urandom_range(0, 7) == 0)
            set_coefs(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom));
         tick();
      end
      muestra_valida = 1'b0;
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
